// File: rtl/prog_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prog_counter_pkg                                            |
// | Brief  : Shared direction and mode encodings for prog_counter.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package prog_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/prog_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prog_counter_if                                             |
// | Brief  : Control and status bundle between a host and prog_counter.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic             sat;
    logic [WIDTH-1:0] cmp_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             match;
    logic             ovf;

    modport master (
        output en, dir, load, load_val, max_val, sat, cmp_val, clr_ovf,
        input  out, tc, match, ovf
    );

    modport slave (
        input  en, dir, load, load_val, max_val, sat, cmp_val, clr_ovf,
        output out, tc, match, ovf
    );
endinterface
`default_nettype wire

// File: rtl/prog_counter_prescale.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : counter_prescale                                            |
// | Brief  : Ticks on every PRESCALE-th enabled cycle; en=0 freezes it.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module counter_prescale #(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr};
            assign tick     = en;
        end else begin : g_count
            localparam int            CW     = $clog2(PRESCALE);
            localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
                end
            end

            assign tick = en & (r_cnt == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prog_counter                                                |
// | Brief  : Up/down modulo counter with load, saturate, prescaler,      |
// |          compare match, terminal-count pulse and sticky overflow.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input wire logic       clk,
    input wire logic       rst,
    prog_counter_if.slave  bus
);

    logic             w_step;
    logic [WIDTH-1:0] w_out_next;
    logic             w_tc_next;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_match;
    logic             r_ovf;

    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (w_step)
    );

    always_comb begin
        w_out_next = r_out;
        w_tc_next  = 1'b0;
        if (bus.load) begin
            w_out_next = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
        end else if (w_step) begin
            // A limit lowered beneath the count snaps back without a tc event
            if (r_out > bus.max_val) begin
                w_out_next = bus.max_val;
            end else if (bus.dir == DIR_UP) begin
                if (r_out == bus.max_val) begin
                    w_tc_next  = 1'b1;
                    w_out_next = (bus.sat == MODE_SAT) ? r_out : '0;
                end else begin
                    w_out_next = r_out + 1'b1;
                end
            end else begin
                if (r_out == '0) begin
                    w_tc_next  = 1'b1;
                    w_out_next = (bus.sat == MODE_SAT) ? '0 : bus.max_val;
                end else begin
                    w_out_next = r_out - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out   <= '0;
            r_tc    <= 1'b0;
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_tc    <= w_tc_next;
            r_match <= (w_out_next == bus.cmp_val);
            if (w_tc_next) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out   = r_out;
    assign bus.tc    = r_tc;
    assign bus.match = r_match;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire
